fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch: small instruction memory feeding a prefetch FIFO that drains into the IF/ID register.
// Latency: first instruction valid in if_id_reg on the 2nd edge after reset release or redirect, then one per cycle.
// Backpressure: stall freezes IF/ID and stops pops; fetch keeps filling the queue until it is full, then waits.
module fetch_queue #(
    parameter int PC_W    = 4,
    parameter int Q_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [PC_W-1:0]          prog_addr,
    input  logic [7:0]               prog_data,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [7:0]               if_id_reg,
    output logic                     if_id_valid,
    output logic [PC_W-1:0]          if_id_pc,
    output logic [$clog2(Q_DEPTH):0] q_count
);

    localparam int AW    = $clog2(Q_DEPTH);
    localparam int CW    = AW + 1;
    localparam int MEM_N = 1 << PC_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(Q_DEPTH);

    logic [7:0]      mem_q [MEM_N];
    logic [7:0]      mem_d [MEM_N];

    logic [7:0]      qdat_q [Q_DEPTH];
    logic [7:0]      qdat_d [Q_DEPTH];
    logic [PC_W-1:0] qpc_q  [Q_DEPTH];
    logic [PC_W-1:0] qpc_d  [Q_DEPTH];

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      if_reg_q, if_reg_d;
    logic            if_vld_q, if_vld_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;

    logic            do_push;
    logic            do_pop;

    // Instruction memory write port; a fetch in the same cycle still reads the old byte
    always_comb begin
        mem_d = mem_q;
        if (prog_we) begin
            mem_d[prog_addr] = prog_data;
        end
    end

    // Memory is not cleared by reset, but reset does block programming writes
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    // Pop and push qualifiers; a pop frees a slot for a push in the same cycle
    always_comb begin
        do_pop  = !redirect && !stall && (count_q != '0);
        do_push = !redirect && ((count_q != DEPTH_C) || do_pop);
    end

    // Next-state for the fetch pointer, the queue and the IF/ID register
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        qdat_d     = qdat_q;
        qpc_d      = qpc_q;
        if_reg_d   = if_reg_q;
        if_vld_d   = if_vld_q;
        if_pc_d    = if_pc_q;

        if (redirect) begin
            // Flush everything in flight and restart fetch at the new address
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if_reg_d   = 8'h00;
            if_vld_d   = 1'b0;
        end else begin
            if (do_push) begin
                qdat_d[wr_ptr_q] = mem_q[fetch_pc_q];
                qpc_d[wr_ptr_q]  = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + AW'(1);
                fetch_pc_d       = fetch_pc_q + PC_W'(1);
            end
            if (!stall) begin
                if (do_pop) begin
                    if_reg_d = qdat_q[rd_ptr_q];
                    if_pc_d  = qpc_q[rd_ptr_q];
                    if_vld_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end else begin
                    // Empty queue: present a NOP bubble, keep the last pc
                    if_reg_d = 8'h00;
                    if_vld_d = 1'b0;
                end
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue payload storage; stale entries are harmless since pointers define occupancy
    always_ff @(posedge clk) begin
        qdat_q <= qdat_d;
        qpc_q  <= qpc_d;
    end

    // Control state and IF/ID register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            if_reg_q   <= 8'h00;
            if_vld_q   <= 1'b0;
            if_pc_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if_reg_q   <= if_reg_d;
            if_vld_q   <= if_vld_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign if_id_reg   = if_reg_q;
    assign if_id_valid = if_vld_q;
    assign if_id_pc    = if_pc_q;
    assign q_count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int Q_DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       stall;
    logic       redirect;
    logic [3:0] redirect_pc;
    logic [7:0] if_id_reg;
    logic       if_id_valid;
    logic [3:0] if_id_pc;
    logic [2:0] q_count;

    fetch_queue #(.PC_W(4), .Q_DEPTH(Q_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_reg   (if_id_reg),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] dat;
    } ent_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] dat;
        logic [3:0] pc;
        logic [2:0] cnt;
    } cyc_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: a plain queue of fetched (pc, byte) pairs
    ent_t       mq[$];
    ent_t       dlv_sb[$];
    cyc_t       cyc_sb[$];
    logic [7:0] m_mem [16];
    logic [3:0] m_pc;
    logic [7:0] m_dat;
    logic       m_vld;
    logic [3:0] m_opc;
    logic       st_rst, st_redir, st_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] tbl(input int i);
        logic [7:0] v;
        case (i)
            0:       v = 8'h13;
            1:       v = 8'h27;
            2:       v = 8'h35;
            3:       v = 8'h4B;
            default: v = 8'(8'h50 + i);
        endcase
        return v;
    endfunction

    task automatic model_step();
        ent_t e;
        cyc_t c;
        st_rst   = reset;
        st_redir = redirect;
        st_stall = stall;
        if (reset) begin
            mq.delete();
            m_pc  = 4'd0;
            m_dat = 8'h00;
            m_vld = 1'b0;
            m_opc = 4'd0;
        end else if (redirect) begin
            mq.delete();
            m_pc  = redirect_pc;
            m_dat = 8'h00;
            m_vld = 1'b0;
        end else begin
            // Pop first so a value fetched this cycle can never be delivered this cycle
            if (!stall) begin
                if (mq.size() > 0) begin
                    e     = mq.pop_front();
                    m_dat = e.dat;
                    m_opc = e.pc;
                    m_vld = 1'b1;
                    dlv_sb.push_back(e);
                end else begin
                    m_dat = 8'h00;
                    m_vld = 1'b0;
                end
            end
            if (mq.size() < Q_DEPTH) begin
                e.pc  = m_pc;
                e.dat = m_mem[m_pc];
                mq.push_back(e);
                m_pc = 4'((32'(m_pc) + 1) % 16);
            end
        end
        if (!reset && prog_we) m_mem[prog_addr] = prog_data;
        c.vld = m_vld;
        c.dat = m_dat;
        c.pc  = m_opc;
        c.cnt = 3'(mq.size());
        cyc_sb.push_back(c);
    endtask

    task automatic monitor_step();
        cyc_t c;
        ent_t e;
        if (cyc_sb.size() == 0) begin
            chk("cyc_sb_nonempty", 32'd0, 32'd1);
        end else begin
            c = cyc_sb.pop_front();
            chk("q_count", 32'(q_count), 32'(c.cnt));
            chk("if_id_valid", 32'(if_id_valid), 32'(c.vld));
            chk("if_id_reg", 32'(if_id_reg), 32'(c.dat));
            chk("if_id_pc", 32'(if_id_pc), 32'(c.pc));
        end
        chk("q_count_bound", 32'(q_count <= 3'd4), 32'd1);
        // A new instruction is presented whenever the last edge was an unstalled, valid cycle
        if (!st_rst && !st_redir && !st_stall && if_id_valid) begin
            if (dlv_sb.size() == 0) begin
                chk("dlv_unexpected", 32'(if_id_pc), 32'hFFFF);
            end else begin
                e = dlv_sb.pop_front();
                chk("dlv_pc", 32'(if_id_pc), 32'(e.pc));
                chk("dlv_dat", 32'(if_id_reg), 32'(e.dat));
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'h00;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 4'd0;
        tick();
        chk("rst_reg", 32'(if_id_reg), 32'h00);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_pc", 32'(if_id_pc), 32'd0);
        chk("rst_count", 32'(q_count), 32'd0);

        // Load memory while redirect holds fetch idle
        reset = 1'b0; redirect = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = tbl(i);
            tick();
        end
        prog_we = 1'b0; redirect = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("first_edge_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("first_reg", 32'(if_id_reg), 32'h13);
        chk("first_pc", 32'(if_id_pc), 32'd0);
        chk("first_valid", 32'(if_id_valid), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("stream_reg", 32'(if_id_reg), 32'(tbl(i)));
            chk("stream_valid", 32'(if_id_valid), 32'd1);
        end

        // Stall for six cycles after the first valid instruction
        reset = 1'b1; tick(); reset = 1'b0; tick(); tick();
        stall = 1'b1;
        repeat (6) tick();
        chk("stall_hold_reg", 32'(if_id_reg), 32'h13);
        chk("stall_full_count", 32'(q_count), 32'd4);
        stall = 1'b0;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("after_stall_reg", 32'(if_id_reg), 32'(tbl(i)));
            chk("after_stall_pc", 32'(if_id_pc), i);
        end

        // Redirect while stalled with a full queue
        stall = 1'b1;
        repeat (4) tick();
        redirect = 1'b1; redirect_pc = 4'hE;
        tick();
        chk("redir_count", 32'(q_count), 32'd0);
        chk("redir_valid", 32'(if_id_valid), 32'd0);
        chk("redir_reg", 32'(if_id_reg), 32'h00);
        redirect = 1'b0; stall = 1'b0;
        tick(); tick();
        chk("redir_pc_e", 32'(if_id_pc), 32'hE);
        chk("redir_dat_e", 32'(if_id_reg), 32'(tbl(14)));
        tick();
        chk("redir_pc_f", 32'(if_id_pc), 32'hF);
        tick();
        chk("redir_pc_wrap", 32'(if_id_pc), 32'h0);
        chk("redir_dat_wrap", 32'(if_id_reg), 32'h13);

        // Write address 5 in the same cycle it is fetched
        redirect = 1'b1; redirect_pc = 4'd5;
        tick();
        redirect = 1'b0; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'hAA;
        tick();
        prog_we = 1'b0;
        tick();
        chk("wr_same_old", 32'(if_id_reg), 32'h55);
        chk("wr_same_pc", 32'(if_id_pc), 32'd5);
        redirect = 1'b1; redirect_pc = 4'd5;
        tick();
        redirect = 1'b0;
        tick(); tick();
        chk("wr_new", 32'(if_id_reg), 32'hAA);

        // Reset mid-stream with three queued entries
        stall = 1'b1;
        tick(); tick();
        chk("pre_rst_count", 32'(q_count), 32'd3);
        chk("pre_rst_valid", 32'(if_id_valid), 32'd1);
        reset = 1'b1; stall = 1'b0;
        tick();
        chk("mid_rst_reg", 32'(if_id_reg), 32'h00);
        chk("mid_rst_valid", 32'(if_id_valid), 32'd0);
        chk("mid_rst_pc", 32'(if_id_pc), 32'd0);
        chk("mid_rst_count", 32'(q_count), 32'd0);
        reset = 1'b0;
        tick(); tick();
        chk("post_rst_reg", 32'(if_id_reg), 32'h13);
        chk("post_rst_valid", 32'(if_id_valid), 32'd1);

        // Random stall / redirect / programming / reset stress
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 99) < 40);
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = 4'($urandom_range(0, 15));
            prog_we     = ($urandom_range(0, 99) < 10);
            prog_addr   = 4'($urandom_range(0, 15));
            prog_data   = 8'($urandom_range(0, 255));
            reset       = ($urandom_range(0, 199) == 0);
            tick();
        end
        stall = 1'b0; redirect = 1'b0; prog_we = 1'b0; reset = 1'b0;
        repeat (10) tick();
        chk("dlv_sb_drained", 32'(dlv_sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
